fir_io_sequencer: RTL and testbench



---
 rtl/fir_seq_pkg.sv | 25 ++
 rtl/fir_io_sequencer_if.sv | 13 +
 rtl/fir_seq_byte_packer.sv | 70 +++++++
 rtl/fir_io_sequencer.sv | 139 +++++++++++++
 tb/tb_fir_io_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// Shared state encoding and sizing helpers for the FIR pin-interface sequencer.
package fir_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } seq_state_e;

  // Number of pin-side transfers per sample (NB).
  function automatic int num_bytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_io_sequencer_if.sv
// Byte-wide valid/ready stream between the pin wrapper and the sequencer.
interface fir_io_sequencer_if #(
  parameter int BYTE_W = 8
) ();

  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/fir_seq_byte_packer.sv
// Byte<->word index unit: PACK=1 assembles bytes into a word, PACK=0 serializes
// a loaded word LSB first. The index returns to zero after the last byte.
module fir_seq_byte_packer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter bit PACK   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  output logic [DATA_W-1:0] word,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last
);

  localparam int NB    = num_bytes(DATA_W, BYTE_W);
  localparam int IDX_W = idx_width(NB);

  logic [IDX_W-1:0] idx;

  assign last = (idx == IDX_W'(NB - 1));

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (step) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

  generate
    if (PACK) begin : g_pack
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word <= '0;
        end else if (step) begin
          word[int'(idx) * BYTE_W +: BYTE_W] <= byte_in;
        end
      end

      assign byte_out = '0;

      logic unused_pack;
      assign unused_pack = ^{load, word_in};
    end else begin : g_unpack
      // NOTE: the word register is reset even though it is data, because the
      // byte it presents is a pin-visible output with a defined reset value.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word <= '0;
        end else if (load) begin
          word <= word_in;
        end
      end

      assign byte_out = word[int'(idx) * BYTE_W +: BYTE_W];

      logic unused_unpack;
      assign unused_unpack = ^byte_in;
    end
  endgenerate

endmodule

// File: rtl/fir_io_sequencer.sv
// Sequences a DATA_W-bit FIR core behind byte-wide pin streams.
// Optional WAIT watchdog enabled by defining FIR_SEQ_TIMEOUT_EN.
module fir_io_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int BYTE_W      = BYTE_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_io_sequencer_if.slave   in_if,
  output logic [DATA_W-1:0]   core_x,
  output logic                core_start,
  input  logic                core_done,
  input  logic [DATA_W-1:0]   core_y,
  fir_io_sequencer_if.master  out_if,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic                err
);

  seq_state_e        state;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;
  logic              pk_last;
  logic              up_last;
  logic              result_load;
  logic [BYTE_W-1:0] up_byte;
  logic [BYTE_W-1:0] unused_pk_byte;
  logic [DATA_W-1:0] unused_result;

  assign in_if.ready  = rst_n && (state == LOAD);
  assign in_fire      = in_if.valid && in_if.ready;
  assign out_fire     = out_valid && out_if.ready;
  assign result_load  = (state == WAIT) && core_done;
  assign out_if.valid = out_valid;
  assign out_if.data  = up_byte;

  fir_seq_byte_packer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .PACK   (1'b1)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (in_fire),
    .byte_in  (in_if.data),
    .load     (1'b0),
    .word_in  ('0),
    .word     (core_x),
    .byte_out (unused_pk_byte),
    .last     (pk_last)
  );

  // The unpacker's word is the result register; it only loads from WAIT.
  fir_seq_byte_packer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .PACK   (1'b0)
  ) u_unpacker (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (out_fire),
    .byte_in  ('0),
    .load     (result_load),
    .word_in  (core_y),
    .word     (unused_result),
    .byte_out (up_byte),
    .last     (up_last)
  );

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int WAIT_W = idx_width(TIMEOUT_CYC);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign err = err_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      sample_cnt <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        LOAD: begin
          if (in_fire && pk_last) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
`ifdef FIR_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          // A done in the limit cycle takes priority over the watchdog.
          if (core_done) begin
            state     <= UNLOAD;
            out_valid <= 1'b1;
          end
`ifdef FIR_SEQ_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
            state <= LOAD;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        UNLOAD: begin
          if (out_fire && up_last) begin
            state      <= LOAD;
            out_valid  <= 1'b0;
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_io_sequencer.sv
// Self-checking bench: a delayed-response core model plus an output byte scoreboard.
module tb_fir_io_sequencer;
  import fir_seq_pkg::*;

  localparam int DATA_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int NB          = DATA_W / BYTE_W;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_io_sequencer_if #(.BYTE_W(BYTE_W)) in_if ();
  fir_io_sequencer_if #(.BYTE_W(BYTE_W)) out_if ();

  logic [DATA_W-1:0] core_x;
  logic [DATA_W-1:0] core_y;
  logic [DATA_W-1:0] model_y;
  logic [DATA_W-1:0] junk_y;
  logic [DATA_W-1:0] core_resp;
  logic              core_start;
  logic              core_done;
  logic              model_done;
  logic              force_done;
  logic              core_mute;
  int                core_delay;
  logic [CNT_W-1:0]  sample_cnt;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [BYTE_W-1:0] sb_q[$];

  assign core_done = model_done | force_done;
  assign core_y    = force_done ? junk_y : model_y;

  fir_io_sequencer #(
    .DATA_W      (DATA_W),
    .BYTE_W      (BYTE_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if),
    .core_x     (core_x),
    .core_start (core_start),
    .core_done  (core_done),
    .core_y     (core_y),
    .out_if     (out_if),
    .sample_cnt (sample_cnt),
    .err        (err)
  );

  // Core model: answers each start with core_resp, core_delay cycles later.
  initial begin
    model_done = 1'b0;
    model_y    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_start && !core_mute) begin
        repeat (core_delay) @(posedge clk);
        #1;
        model_done = 1'b1;
        model_y    = core_resp;
        @(posedge clk);
        #1;
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [DATA_W-1:0] y);
    for (int i = 0; i < NB; i++) sb_q.push_back(y[i*BYTE_W +: BYTE_W]);
  endtask

  task automatic send_byte(input logic [BYTE_W-1:0] b);
    int budget = 100;
    while (!in_if.ready && budget > 0) begin
      tick();
      budget--;
    end
    check("in_ready_wait", in_if.ready, 1);
    in_if.valid = 1'b1;
    in_if.data  = b;
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] x);
    for (int i = 0; i < NB; i++) send_byte(x[i*BYTE_W +: BYTE_W]);
  endtask

  task automatic recv_sample();
    int n = 0;
    int budget = 200;
    logic [BYTE_W-1:0] exp_b;
    while (n < NB && budget > 0) begin
      if (out_if.valid) begin
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        check("out_byte", out_if.data, exp_b);
        out_if.ready = 1'b1;
        n++;
      end else begin
        out_if.ready = 1'b0;
      end
      tick();
      budget--;
    end
    out_if.ready = 1'b0;
    check("recv_count", n, NB);
    exp_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      tick();
      check("rst_in_ready", in_if.ready, 0);
      check("rst_out_valid", out_if.valid, 0);
      check("rst_sample_cnt", sample_cnt, 0);
      check("rst_err", err, 0);
    end
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    force_done   = 1'b0;
    junk_y       = 32'h0BAD_0BAD;
    core_resp    = '0;
    core_delay   = 5;
    core_mute    = 1'b0;

    // Reset state and first cycle after release.
    do_reset(2);
    check("rst_core_x", core_x, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_byte", out_if.data, 0);
    tick();
    check("post_rst_in_ready", in_if.ready, 1);

    // Basic sample, start pulse timing, done-to-valid latency, output stall.
    core_resp = 32'hDEAD_BEEF;
    push_result(core_resp);
    send_sample(32'h4433_2211);
    check("start_pulse", core_start, 1);
    check("core_x_1", core_x, 32'h4433_2211);
    check("start_in_ready", in_if.ready, 0);
    tick();
    check("start_once", core_start, 0);
    repeat (4) tick();
    check("done_cycle_no_valid", out_if.valid, 0);
    tick();
    check("valid_after_done", out_if.valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_if.valid = i[0];
      in_if.data  = 8'h5A;
      check("stall_valid", out_if.valid, 1);
      check("stall_byte", out_if.data, 8'hEF);
      check("stall_in_ready", in_if.ready, 0);
      tick();
    end
    in_if.valid = 1'b0;
    recv_sample();
    check("turnaround_in_ready", in_if.ready, 1);
    check("sample_cnt_1", sample_cnt, exp_cnt);

    // Spurious done in LOAD and in START must be ignored.
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (2) begin
      check("spur_load_valid", out_if.valid, 0);
      check("spur_load_ready", in_if.ready, 1);
      tick();
    end
    core_resp = 32'h0BAD_F00D;
    push_result(core_resp);
    send_sample(32'h8877_6655);
    check("core_x_2", core_x, 32'h8877_6655);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("spur_start_valid", out_if.valid, 0);
    check("spur_start_in_ready", in_if.ready, 0);
    recv_sample();
    check("sample_cnt_2", sample_cnt, exp_cnt);

    // Reset mid-LOAD discards the partial bytes.
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset(1);
    tick();
    check("midload_in_ready", in_if.ready, 1);
    core_resp = 32'h1234_5678;
    push_result(core_resp);
    send_sample(32'hDDCC_BBAA);
    check("core_x_3", core_x, 32'hDDCC_BBAA);
    recv_sample();
    check("sample_cnt_3", sample_cnt, exp_cnt);

    // Reset mid-WAIT discards the pending result; the late done is ignored.
    core_resp = 32'hFFFF_0000;
    send_sample(32'hCAFE_F00D);
    repeat (2) tick();
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      check("midwait_no_valid", out_if.valid, 0);
      tick();
    end
    check("midwait_in_ready", in_if.ready, 1);
    core_resp = 32'hA5C3_3C5A;
    push_result(core_resp);
    send_sample(32'h0F1E_2D3C);
    check("core_x_4", core_x, 32'h0F1E_2D3C);
    recv_sample();
    check("sample_cnt_4", sample_cnt, exp_cnt);

`ifdef FIR_SEQ_TIMEOUT_EN
    // Watchdog: no done for TIMEOUT_CYC WAIT cycles drops the sample.
    core_mute = 1'b1;
    send_sample(32'h0000_0001);
    repeat (TIMEOUT_CYC) tick();
    check("to_last_wait_ready", in_if.ready, 0);
    check("to_err_early", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_in_ready", in_if.ready, 1);
    check("to_sample_cnt", sample_cnt, exp_cnt);
    check("to_no_valid", out_if.valid, 0);

    // Done in the limit cycle wins over the watchdog.
    core_mute  = 1'b0;
    core_delay = TIMEOUT_CYC;
    do_reset(1);
    tick();
    core_resp = 32'h5566_7788;
    push_result(core_resp);
    send_sample(32'h0000_0002);
    repeat (TIMEOUT_CYC) tick();
    check("limit_done_no_valid", out_if.valid, 0);
    tick();
    check("limit_done_valid", out_if.valid, 1);
    check("limit_done_err", err, 0);
    recv_sample();
    check("limit_err_after", err, 0);
    check("limit_sample_cnt", sample_cnt, exp_cnt);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
